// File: rtl/puf_crp_pkg.sv
// Shared types and constants for the RO PUF challenge/response verifier.
package puf_crp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PUF_RST,
        MEASURE,
        CAPTURE,
        COMPARE,
        DONE
    } state_t;

    localparam int          PUF_RST_CYCLES    = 2;
    localparam int          DEFAULT_WIDTH     = 22;
    localparam logic [21:0] DEFAULT_LFSR_TAPS = 22'h300000;

endpackage

// File: rtl/puf_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module puf_popcount
    import puf_crp_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_WIDTH,
    localparam int PW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [PW-1:0]    count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + PW'(bits[i]);
        end
    end

endmodule

// File: rtl/puf_crp_verifier.sv
// Issues LFSR challenges to the RO PUF, checks responses against enrolled values and
// accumulates Hamming distance. Define PUF_CRP_MAJORITY_EN for 3-sample majority voting.
module puf_crp_verifier
    import puf_crp_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter int               NUM_CRP     = 16,
    parameter int               MEAS_CYCLES = 1024,
    parameter int               HD_THRESH   = 8,
    parameter logic [WIDTH-1:0] LFSR_TAPS   = DEFAULT_LFSR_TAPS,
    localparam int              HDW         = $clog2(WIDTH * NUM_CRP + 1),
    localparam int              CW          = $clog2(NUM_CRP + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] puf_chal,
    output logic             puf_enable,
    output logic             puf_reset,
    input  logic [WIDTH-1:0] puf_resp,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [WIDTH-1:0] exp_resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [HDW-1:0]   hd_total,
    output logic [CW-1:0]    crp_idx
);

    localparam int          TMAX   = (MEAS_CYCLES > PUF_RST_CYCLES) ? MEAS_CYCLES : PUF_RST_CYCLES;
    localparam int          TW     = $clog2(TMAX + 1);
    localparam int          PW     = $clog2(WIDTH + 1);
    localparam logic [31:0] THRESH = 32'(HD_THRESH);
`ifdef PUF_CRP_MAJORITY_EN
    // One extra MEASURE cycle with the enable low latches each of the three samples.
    localparam int          MEAS_LAST = MEAS_CYCLES;
`else
    localparam int          MEAS_LAST = MEAS_CYCLES - 1;
`endif

    state_t           state, next_state;
    logic [TW-1:0]    timer;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] resp_sel;
    logic [PW-1:0]    diff_ones;
    logic [HDW-1:0]   hd_next;
    logic             rst_last, meas_last, last_pair;

    assign rst_last  = (timer == TW'(PUF_RST_CYCLES - 1));
    assign meas_last = (timer == TW'(MEAS_LAST));
    assign last_pair = (crp_idx == CW'(NUM_CRP - 1));
    assign hd_next   = hd_total + HDW'(diff_ones);
    assign puf_chal  = lfsr;

    puf_popcount #(.WIDTH(WIDTH)) u_popcount (
        .bits  (diff),
        .count (diff_ones)
    );

`ifdef PUF_CRP_MAJORITY_EN
    logic [1:0]       rep;
    logic [WIDTH-1:0] samp0, samp1, samp2;

    assign resp_sel = (samp0 & samp1) | (samp0 & samp2) | (samp1 & samp2);

    always_ff @(posedge clk) begin
        if (reset) begin
            rep   <= '0;
            samp0 <= '0;
            samp1 <= '0;
            samp2 <= '0;
        end else if (state == MEASURE && meas_last) begin
            samp0 <= samp1;
            samp1 <= samp2;
            samp2 <= puf_resp;
            rep   <= (rep == 2'd2) ? 2'd0 : rep + 2'd1;
        end
    end
`else
    assign resp_sel = puf_resp;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = PUF_RST;
            PUF_RST: if (rst_last) next_state = MEASURE;
`ifdef PUF_CRP_MAJORITY_EN
            MEASURE: if (meas_last) next_state = (rep == 2'd2) ? CAPTURE : PUF_RST;
`else
            MEASURE: if (meas_last) next_state = CAPTURE;
`endif
            CAPTURE: if (exp_valid) next_state = COMPARE;
            COMPARE: next_state = last_pair ? DONE : PUF_RST;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        puf_enable = 1'b0;
        puf_reset  = 1'b0;
        exp_ready  = 1'b0;
        done       = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE, PUF_RST: puf_reset = 1'b1;
`ifdef PUF_CRP_MAJORITY_EN
            MEASURE:       puf_enable = (timer < TW'(MEAS_CYCLES));
`else
            MEASURE:       puf_enable = 1'b1;
`endif
            CAPTURE:       exp_ready = 1'b1;
            DONE:          done = 1'b1;
            default:       ;
        endcase
    end

    // Phase timer restarts on every state change so each phase counts from zero.
    always_ff @(posedge clk) begin
        if (reset || state != next_state) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr     <= '0;
            diff     <= '0;
            hd_total <= '0;
            crp_idx  <= '0;
            pass     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lfsr     <= (seed == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed;
                        hd_total <= '0;
                        crp_idx  <= '0;
                        pass     <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (exp_valid) diff <= resp_sel ^ exp_resp;
                end
                COMPARE: begin
                    hd_total <= hd_next;
                    if (last_pair) begin
                        // Judged here so pass is already valid during the done pulse.
                        pass <= (32'(hd_next) <= THRESH);
                    end else begin
                        crp_idx <= crp_idx + CW'(1);
                        lfsr    <= {lfsr[WIDTH-2:0], ^(lfsr & LFSR_TAPS)};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_crp_verifier.sv
// Randomized self-checking bench for puf_crp_verifier against a behavioural CRP model.
module tb_puf_crp_verifier;

    localparam int W     = 22;
    localparam int NC    = 4;
    localparam int MC    = 16;
    localparam int THR   = 8;
    localparam int MC1   = 8;
    localparam int HDW   = $clog2(W * NC + 1);
    localparam int CW    = $clog2(NC + 1);
    localparam int HDW1  = $clog2(W + 1);
    localparam int LIMIT = 4 * (MC + 8) + 60;

    logic           clk = 1'b0;
    logic           reset, start, exp_valid, puf_enable, puf_reset, exp_ready, busy, done, pass;
    logic [W-1:0]   seed, puf_resp, exp_resp, puf_chal;
    logic [HDW-1:0] hd_total;
    logic [CW-1:0]  crp_idx;

    logic            start_s, expv_s, en_s, prst_s, rdy_s, busy_s, done_s, pass_s;
    logic [W-1:0]    seed_s, resp_s, expr_s, chal_s;
    logic [HDW1-1:0] hd_s;
    logic [0:0]      idx_s;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int en_run = 0;
    int rst_run = 0;
    int done_count = 0;
    logic en_prev = 1'b0;

    puf_crp_verifier #(.WIDTH(W), .NUM_CRP(NC), .MEAS_CYCLES(MC), .HD_THRESH(THR)) dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed), .puf_chal(puf_chal),
        .puf_enable(puf_enable), .puf_reset(puf_reset), .puf_resp(puf_resp),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_resp(exp_resp), .busy(busy),
        .done(done), .pass(pass), .hd_total(hd_total), .crp_idx(crp_idx)
    );

    puf_crp_verifier #(.WIDTH(W), .NUM_CRP(1), .MEAS_CYCLES(MC1), .HD_THRESH(THR)) dut_single (
        .clk(clk), .reset(reset), .start(start_s), .seed(seed_s), .puf_chal(chal_s),
        .puf_enable(en_s), .puf_reset(prst_s), .puf_resp(resp_s),
        .exp_valid(expv_s), .exp_ready(rdy_s), .exp_resp(expr_s), .busy(busy_s),
        .done(done_s), .pass(pass_s), .hd_total(hd_s), .crp_idx(idx_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Next challenge: shift left, feed in the parity of the tapped bits (x^22+x^21+1).
    function automatic logic [21:0] model_next(input logic [21:0] x);
        int unsigned v;
        int unsigned fb;
        v  = x;
        fb = $countones(x & 22'h300000) % 2;
        return 22'(((v << 1) | fb) & 32'h3FFFFF);
    endfunction

    function automatic logic [21:0] rand_mask(input int nb);
        logic [21:0] m;
        m = '0;
        while ($countones(m) < nb) m[$urandom_range(0, 21)] = 1'b1;
        return m;
    endfunction

    // Enable window width and the reset pulse leading into each window.
    always @(negedge clk) begin
        if (reset) begin
            en_run  = 0;
            rst_run = 0;
            en_prev = 1'b0;
        end else begin
            if (done) done_count++;
            if (puf_enable && !en_prev) checkOutput("rst_width", rst_run, 2);
            if (puf_enable) begin
                en_run++;
            end else if (en_prev) begin
                checkOutput("en_width", en_run, MC);
                en_run = 0;
            end
            if (puf_reset && busy) rst_run++;
            else if (!puf_reset) rst_run = 0;
            en_prev = puf_enable;
        end
    end

    task automatic single_run();
        int c0, n;
        logic [21:0] r;
        @(negedge clk);
        seed_s  = '0;
        start_s = 1'b1;
        c0      = cycle;
        @(negedge clk);
        start_s = 1'b0;
        n = 0;
        while (!rdy_s && n < LIMIT) begin @(negedge clk); n++; end
        checkOutput("single_capture", rdy_s, 1);
        checkOutput("single_chal", chal_s, 22'h000001);
        r      = 22'($urandom);
        resp_s = r;
        expr_s = r;
        expv_s = 1'b1;
        @(negedge clk);
        expv_s = 1'b0;
        n = 0;
        while (!done_s && n < LIMIT) begin @(negedge clk); n++; end
        checkOutput("single_done", done_s, 1);
        checkOutput("single_latency", cycle - c0, MC1 + 4 + 1);
        checkOutput("single_hd", hd_s, 0);
        checkOutput("single_pass", pass_s, 1);
        @(negedge clk);
        checkOutput("single_done_pulse", {done_s, busy_s}, 0);
    endtask

    task automatic applyStimulus(input logic [21:0] seed_v, input int fixed_bits,
                                 input int stall_pair, input int abort_pair);
        logic [21:0] chal, mask, r;
        int exp_hd, c0, dc0, n, nb;
        chal   = (seed_v == '0) ? 22'h000001 : seed_v;
        exp_hd = 0;
        dc0    = done_count;
        @(negedge clk);
        seed  = seed_v;
        start = 1'b1;
        c0    = cycle;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < NC; k++) begin
            if (k == abort_pair) begin
                n = 0;
                while (!puf_enable && n < LIMIT) begin @(negedge clk); n++; end
                checkOutput("abort_in_measure", puf_enable, 1);
                checkOutput("abort_idx", crp_idx, k);
                repeat (5) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                checkOutput("abort_chal", puf_chal, 0);
                checkOutput("abort_outs", {hd_total, crp_idx, pass, done, exp_ready, busy, puf_enable, puf_reset}, 1);
                reset = 1'b0;
                repeat (20) @(negedge clk);
                checkOutput("abort_no_done", done_count - dc0, 0);
                checkOutput("abort_idle", busy, 0);
                return;
            end
            n = 0;
            while (!exp_ready && n < LIMIT) begin @(negedge clk); n++; end
            checkOutput("capture_reached", exp_ready, 1);
            if (!exp_ready) return;
            checkOutput("chal", puf_chal, chal);
            checkOutput("crp_idx", crp_idx, k);
            if (k == stall_pair) begin
                for (int i = 0; i < 50; i++) begin
                    start = (i == 10 || i == 30);
                    @(negedge clk);
                end
                start = 1'b0;
                checkOutput("stall_ready", exp_ready, 1);
                checkOutput("stall_idx", crp_idx, k);
                checkOutput("stall_chal", puf_chal, chal);
            end
            nb        = (fixed_bits >= 0) ? fixed_bits : $urandom_range(0, 4);
            mask      = rand_mask(nb);
            r         = 22'($urandom);
            puf_resp  = r;
            exp_resp  = r ^ mask;
            exp_valid = 1'b1;
            exp_hd   += nb;
            @(negedge clk);
            exp_valid = 1'b0;
            chal = model_next(chal);
        end
        n = 0;
        while (!done && n < LIMIT) begin @(negedge clk); n++; end
        checkOutput("done_seen", done, 1);
        if (stall_pair < 0) checkOutput("latency", cycle - c0, NC * (MC + 4) + 1);
        checkOutput("hd_total", hd_total, exp_hd);
        checkOutput("pass", pass, exp_hd <= THR);
        @(negedge clk);
        checkOutput("done_pulse", {done, busy}, 0);
        checkOutput("done_count", done_count - dc0, 1);
        checkOutput("pass_hold", pass, exp_hd <= THR);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        seed      = '0;
        puf_resp  = '0;
        exp_resp  = '0;
        exp_valid = 1'b0;
        start_s   = 1'b0;
        seed_s    = '0;
        resp_s    = '0;
        expr_s    = '0;
        expv_s    = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_chal", puf_chal, 0);
        checkOutput("reset_outs", {hd_total, crp_idx, pass, done, exp_ready, busy, puf_enable, puf_reset}, 1);
        start = 1'b1;
        @(negedge clk);
        checkOutput("reset_beats_start", busy, 0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        single_run();
        applyStimulus(22'h2AAAAA, 2, -1, -1);
        applyStimulus(22'h2AAAAA, 3, -1, -1);
        for (int i = 0; i < 3; i++) applyStimulus(22'($urandom), -1, -1, -1);
        applyStimulus(22'($urandom), -1, 1, -1);
        applyStimulus(22'($urandom), 1, -1, 2);
        applyStimulus(22'($urandom), -1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
